// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006_pkg: shared types for the execute stage and its IDU/LSU interfaces.
package ysyx_24080006_pkg;
    localparam int REG_WIDTH = 5;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_CSR
    } alu_op_e;
    typedef enum logic [2:0] {BR_NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU} br_type_e;
    typedef enum logic [1:0] {EX_IDLE, EX_SEND, EX_COMMIT} exu_fsm_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] csr_rdata;
        logic        is_zc;
        logic        flush;
        logic        valid;
    } stage_t;
    typedef struct packed {
        alu_op_e              alu_op;
        br_type_e             br_type;
        logic                 is_jump;
        logic                 is_jalr;
        logic                 is_load;
        logic                 is_store;
        logic                 reg_we;
        logic [REG_WIDTH-1:0] rd;
        logic [31:0]          imm;
    } decoder_t;
    typedef struct packed {
        logic                 valid;
        logic [31:0]          pc;
        logic [31:0]          result;
        logic [31:0]          store_data;
        logic                 is_load;
        logic                 is_store;
        logic                 reg_we;
        logic [REG_WIDTH-1:0] rd;
    } exu2lsu_t;
endpackage

// File: rtl/ysyx_24080006_alu.sv
// ysyx_24080006_alu: combinational ALU with compare flags for branch resolution.
module ysyx_24080006_alu
    import ysyx_24080006_pkg::*;
(
    input  alu_op_e     i_alu_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_eq,
    output logic        o_lt,
    output logic        o_ltu
);
    assign o_eq  = i_a == i_b;
    assign o_lt  = $signed(i_a) < $signed(i_b);
    assign o_ltu = i_a < i_b;
    always_comb begin
        o_result = i_a + i_b;
        case (i_alu_op)
            ALU_SUB:   o_result = i_a - i_b;
            ALU_SLL:   o_result = i_a << i_b[4:0];
            ALU_SLT:   o_result = {31'd0, o_lt};
            ALU_SLTU:  o_result = {31'd0, o_ltu};
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SRL:   o_result = i_a >> i_b[4:0];
            ALU_SRA:   o_result = $signed(i_a) >>> i_b[4:0];
            ALU_OR:    o_result = i_a | i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_PASSB: o_result = i_b;
            default:   o_result = i_a + i_b;
        endcase
    end
endmodule

// File: rtl/ysyx_24080006_ex_stage.sv
// ysyx_24080006_ex_stage: execute stage; one instruction in flight from IDU accept to WBU retire.
module ysyx_24080006_ex_stage
    import ysyx_24080006_pkg::*;
#(
    parameter int RESET_PC_ALIGN = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  stage_t               idu2exu,
    input  decoder_t             decoder,
    output logic                 exu2idu_ready,
    output exu2lsu_t             exu2lsu,
    input  logic                 lsu2exu_ready,
    input  logic                 wb_valid,
    input  logic [31:0]          wb_data,
    output logic [REG_WIDTH-1:0] rd_addr,
    output logic                 forward_en,
    output logic [31:0]          forward_data,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc
);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << RESET_PC_ALIGN) - 32'd1);
    exu_fsm_e             r_state;
    logic                 r_ready;
    exu2lsu_t             r_lsu;
    logic [REG_WIDTH-1:0] r_rd;
    logic                 r_redir_v;
    logic [31:0]          r_redir_pc;
    logic [31:0]          w_alu_res;
    logic                 w_eq;
    logic                 w_lt;
    logic                 w_ltu;
    logic                 w_fire;
    logic                 w_taken;
    logic                 w_jump;
    logic                 w_redir;
    logic [31:0]          w_target;
    logic [31:0]          w_result;
    ysyx_24080006_alu u_alu (
        .i_alu_op (decoder.alu_op),
        .i_a      (idu2exu.alu_a),
        .i_b      (idu2exu.alu_b),
        .o_result (w_alu_res),
        .o_eq     (w_eq),
        .o_lt     (w_lt),
        .o_ltu    (w_ltu)
    );
    assign w_fire   = idu2exu.valid && r_ready;
    assign w_jump   = decoder.is_jump || decoder.is_jalr;
    assign w_taken  = (decoder.br_type == BEQ)  ? w_eq  :
                      (decoder.br_type == BNE)  ? !w_eq :
                      (decoder.br_type == BLT)  ? w_lt  :
                      (decoder.br_type == BGE)  ? !w_lt :
                      (decoder.br_type == BLTU) ? w_ltu :
                      (decoder.br_type == BGEU) ? !w_ltu : 1'b0;
    assign w_redir  = w_jump || w_taken;
    assign w_target = (decoder.is_jalr ? idu2exu.rs1_data + decoder.imm
                                       : idu2exu.pc + decoder.imm) & ALIGN_MASK;
    // Link value is computed here so the IDU need not route pc/4 into alu_a/alu_b for jumps.
    assign w_result = w_jump ? idu2exu.pc + (idu2exu.is_zc ? 32'd2 : 32'd4) :
                      (decoder.alu_op == ALU_CSR) ? idu2exu.csr_rdata : w_alu_res;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= EX_IDLE;
            r_ready    <= 1'b0;
            r_lsu      <= '0;
            r_rd       <= '0;
            r_redir_v  <= 1'b0;
            r_redir_pc <= '0;
        end else begin
            r_redir_v <= 1'b0;
            case (r_state)
                EX_IDLE: begin
                    r_ready <= !w_fire;
                    if (w_fire && !idu2exu.flush) begin
                        r_lsu <= '{valid: 1'b1, pc: idu2exu.pc, result: w_result,
                                   store_data: idu2exu.rs2_data, is_load: decoder.is_load,
                                   is_store: decoder.is_store, reg_we: decoder.reg_we,
                                   rd: decoder.rd};
                        r_rd       <= decoder.reg_we ? decoder.rd : '0;
                        r_redir_v  <= w_redir;
                        r_redir_pc <= w_redir ? w_target : r_redir_pc;
                        r_state    <= EX_SEND;
                    end
                end
                EX_SEND: begin
                    if (lsu2exu_ready) begin
                        r_lsu.valid <= 1'b0;
                        r_state     <= EX_COMMIT;
                    end
                end
                EX_COMMIT: begin
                    if (wb_valid) begin
                        r_rd    <= '0;
                        r_ready <= 1'b1;
                        r_state <= EX_IDLE;
                    end
                end
                default: r_state <= EX_IDLE;
            endcase
        end
    end
    assign exu2idu_ready  = r_ready;
    assign exu2lsu        = r_lsu;
    assign rd_addr        = r_rd;
    assign redirect_valid = r_redir_v;
    assign redirect_pc    = r_redir_pc;
    assign forward_en     = (r_state == EX_COMMIT) && wb_valid && (r_rd != '0);
    assign forward_data   = forward_en ? wb_data : '0;
endmodule

// File: tb/tb_ysyx_24080006_ex_stage.sv
// tb_ysyx_24080006_ex_stage: directed bench with a queue scoreboard of expected LSU packets.
module tb_ysyx_24080006_ex_stage;
    import ysyx_24080006_pkg::*;
    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    stage_t               idu2exu;
    decoder_t             decoder;
    logic                 exu2idu_ready;
    exu2lsu_t             exu2lsu;
    logic                 lsu2exu_ready;
    logic                 wb_valid;
    logic [31:0]          wb_data;
    logic [REG_WIDTH-1:0] rd_addr;
    logic                 forward_en;
    logic [31:0]          forward_data;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    int                   n_tests = 0;
    int                   n_fail  = 0;
    exu2lsu_t             exp_q[$];

    ysyx_24080006_ex_stage #(.RESET_PC_ALIGN(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .idu2exu        (idu2exu),
        .decoder        (decoder),
        .exu2idu_ready  (exu2idu_ready),
        .exu2lsu        (exu2lsu),
        .lsu2exu_ready  (lsu2exu_ready),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .rd_addr        (rd_addr),
        .forward_en     (forward_en),
        .forward_data   (forward_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        idu2exu = '0;
        decoder = '0;
        decoder.alu_op  = ALU_ADD;
        decoder.br_type = BR_NONE;
    endtask

    task automatic fire(input logic [31:0] exp_res, input logic exp_rv, input logic [31:0] exp_rpc);
        exu2lsu_t e;
        chk("ready_before", {31'd0, exu2idu_ready}, 32'd1);
        e = '{valid: 1'b1, pc: idu2exu.pc, result: exp_res, store_data: idu2exu.rs2_data,
              is_load: decoder.is_load, is_store: decoder.is_store, reg_we: decoder.reg_we,
              rd: decoder.rd};
        if (!idu2exu.flush) exp_q.push_back(e);
        idu2exu.valid = 1'b1;
        tick();
        idu2exu.valid = 1'b0;
        chk("ready_drop", {31'd0, exu2idu_ready}, 32'd0);
        chk("redir_v", {31'd0, redirect_valid}, {31'd0, exp_rv});
        if (exp_rv) chk("redir_pc", redirect_pc, exp_rpc);
        chk("rd_addr_set", {27'd0, rd_addr},
            (!idu2exu.flush && decoder.reg_we) ? {27'd0, decoder.rd} : 32'd0);
        chk("lsu_valid_set", {31'd0, exu2lsu.valid}, {31'd0, !idu2exu.flush});
        if (idu2exu.flush) begin
            tick();
            chk("flush_ready_back", {31'd0, exu2idu_ready}, 32'd1);
            chk("flush_no_redir", {31'd0, redirect_valid}, 32'd0);
            chk("flush_no_lsu", {31'd0, exu2lsu.valid}, 32'd0);
            chk("flush_rd0", {27'd0, rd_addr}, 32'd0);
        end else begin
            tick();
            chk("redir_one_cycle", {31'd0, redirect_valid}, 32'd0);
        end
    endtask

    task automatic lsu_accept(input int hold);
        exu2lsu_t e;
        for (int i = 0; i < 4 && exu2lsu.valid !== 1'b1; i++) tick();
        chk("lsu_valid_wait", {31'd0, exu2lsu.valid}, 32'd1);
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_nonempty: observed size 0 expected >0");
        end
        if (exp_q.size() == 0) return;
        e = exp_q[0];
        for (int i = 0; i < hold; i++) begin
            wb_valid = 1'b1;
            wb_data  = 32'hBAD0_0000 + i;
            #1;
            chk("hold_no_fwd", {31'd0, forward_en}, 32'd0);
            chk("hold_valid", {31'd0, exu2lsu.valid}, 32'd1);
            chk("hold_result", exu2lsu.result, e.result);
            chk("hold_rd", {27'd0, exu2lsu.rd}, {27'd0, e.rd});
            tick();
        end
        lsu2exu_ready = 1'b1;
        chk("lsu_pc", exu2lsu.pc, e.pc);
        chk("lsu_result", exu2lsu.result, e.result);
        chk("lsu_store_data", exu2lsu.store_data, e.store_data);
        chk("lsu_ctrl", {24'd0, exu2lsu.is_load, exu2lsu.is_store, exu2lsu.reg_we, exu2lsu.rd},
            {24'd0, e.is_load, e.is_store, e.reg_we, e.rd});
        void'(exp_q.pop_front());
        tick();
        lsu2exu_ready = 1'b0;
        wb_valid      = 1'b0;
        chk("lsu_valid_drop", {31'd0, exu2lsu.valid}, 32'd0);
    endtask

    task automatic retire(input logic [31:0] data, input logic [4:0] exp_rd);
        chk("commit_rd", {27'd0, rd_addr}, {27'd0, exp_rd});
        tick();
        chk("commit_wait_ready", {31'd0, exu2idu_ready}, 32'd0);
        wb_valid = 1'b1;
        wb_data  = data;
        #1;
        chk("fwd_en", {31'd0, forward_en}, {31'd0, exp_rd != 5'd0});
        if (exp_rd != 5'd0) chk("fwd_data", forward_data, data);
        tick();
        wb_valid = 1'b0;
        chk("retire_rd0", {27'd0, rd_addr}, 32'd0);
        chk("retire_ready", {31'd0, exu2idu_ready}, 32'd1);
    endtask

    initial begin
        clear_in();
        lsu2exu_ready = 1'b0;
        wb_valid      = 1'b0;
        wb_data       = 32'h1234_5678;
        repeat (3) tick();
        chk("rst_ready", {31'd0, exu2idu_ready}, 32'd0);
        chk("rst_lsu", exu2lsu.result | {31'd0, exu2lsu.valid}, 32'd0);
        chk("rst_rd", {27'd0, rd_addr}, 32'd0);
        chk("rst_redir", redirect_pc | {31'd0, redirect_valid}, 32'd0);
        chk("rst_fwd", forward_data | {31'd0, forward_en}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_ready_low", {31'd0, exu2idu_ready}, 32'd0);
        tick();
        chk("rel_ready_high", {31'd0, exu2idu_ready}, 32'd1);

        clear_in();
        idu2exu.pc = 32'h8000_0000; idu2exu.alu_a = 32'd7; idu2exu.alu_b = 32'd5;
        idu2exu.rs2_data = 32'h55; decoder.reg_we = 1'b1; decoder.rd = 5'd5;
        fire(32'd12, 1'b0, 32'd0);
        lsu_accept(3);
        retire(32'd12, 5'd5);

        clear_in();
        idu2exu.pc = 32'h8000_0010; idu2exu.alu_a = 32'd3; idu2exu.alu_b = 32'd3;
        decoder.alu_op = ALU_SUB; decoder.br_type = BEQ; decoder.imm = 32'hFFFF_FFF0;
        fire(32'd0, 1'b1, 32'h8000_0000);
        lsu_accept(0);
        retire(32'd0, 5'd0);

        idu2exu.alu_b = 32'd4;
        fire(32'hFFFF_FFFF, 1'b0, 32'd0);
        lsu_accept(0);
        retire(32'd0, 5'd0);

        clear_in();
        idu2exu.pc = 32'h8000_0100; idu2exu.rs1_data = 32'h8000_1003; idu2exu.is_zc = 1'b1;
        decoder.is_jalr = 1'b1; decoder.imm = 32'd4; decoder.reg_we = 1'b1; decoder.rd = 5'd1;
        fire(32'h8000_0102, 1'b1, 32'h8000_1006);
        lsu_accept(1);
        retire(32'h8000_0102, 5'd1);

        clear_in();
        idu2exu.pc = 32'h8000_0200; decoder.is_jump = 1'b1; decoder.imm = 32'h20;
        decoder.reg_we = 1'b1; decoder.rd = 5'd2;
        fire(32'h8000_0204, 1'b1, 32'h8000_0220);
        lsu_accept(0);
        retire(32'h8000_0204, 5'd2);

        clear_in();
        idu2exu.alu_a = 32'hFFFF_FFFF; idu2exu.alu_b = 32'd1; decoder.br_type = BLT;
        decoder.imm = 32'h40; idu2exu.pc = 32'h8000_0300;
        fire(32'd0, 1'b1, 32'h8000_0340);
        lsu_accept(0);
        retire(32'd0, 5'd0);
        decoder.br_type = BLTU;
        fire(32'd0, 1'b0, 32'd0);
        lsu_accept(0);
        retire(32'd0, 5'd0);

        clear_in();
        idu2exu.flush = 1'b1; decoder.reg_we = 1'b1; decoder.rd = 5'd3;
        decoder.is_jump = 1'b1; decoder.imm = 32'h100;
        fire(32'd0, 1'b0, 32'd0);

        clear_in();
        idu2exu.alu_a = 32'h8000_0000; idu2exu.alu_b = 32'h21; decoder.alu_op = ALU_SRA;
        decoder.reg_we = 1'b1; decoder.rd = 5'd6;
        fire(32'hC000_0000, 1'b0, 32'd0);
        lsu_accept(0);
        retire(32'hC000_0000, 5'd6);
        idu2exu.alu_a = 32'd1; idu2exu.alu_b = 32'hFFFF_FFFF; decoder.alu_op = ALU_SLTU;
        fire(32'd1, 1'b0, 32'd0);
        lsu_accept(0);
        retire(32'd1, 5'd6);
        decoder.alu_op = ALU_SLT;
        fire(32'd0, 1'b0, 32'd0);
        lsu_accept(0);
        retire(32'd0, 5'd6);
        idu2exu.csr_rdata = 32'hDEAD_BEEF; decoder.alu_op = ALU_CSR; decoder.is_store = 1'b1;
        idu2exu.rs2_data = 32'hCAFE_0001;
        fire(32'hDEAD_BEEF, 1'b0, 32'd0);
        lsu_accept(0);
        retire(32'hDEAD_BEEF, 5'd6);

        clear_in();
        idu2exu.alu_a = 32'd9; decoder.reg_we = 1'b1; decoder.rd = 5'd7;
        fire(32'd9, 1'b0, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_lsu", {31'd0, exu2lsu.valid}, 32'd0);
        chk("mid_rst_result", exu2lsu.result, 32'd0);
        chk("mid_rst_rd", {27'd0, rd_addr}, 32'd0);
        chk("mid_rst_ready", {31'd0, exu2idu_ready}, 32'd0);
        exp_q.delete();
        #2;
        reset = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, exu2idu_ready}, 32'd1);
        wb_valid = 1'b1;
        wb_data  = 32'h7777_7777;
        #1;
        chk("post_rst_no_fwd", {31'd0, forward_en}, 32'd0);
        tick();
        wb_valid = 1'b0;
        chk("post_rst_rd", {27'd0, rd_addr}, 32'd0);
        chk("post_rst_ready_hold", {31'd0, exu2idu_ready}, 32'd1);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
